// File: rtl/multicycle_control.sv
// Sequencing FSM for the multicycle RV32I core: steps the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB with ready-handshake wait states, sticky trap flags.
module multicycle_control #(
    parameter int WAIT_MAX = 15
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       RUN,
    input  logic [6:0] OPCODE,
    input  logic       BR_TAKEN,
    input  logic       MEM_READY,
    output logic       PC_WRITE,
    output logic [1:0] PC_SRC,
    output logic       IR_WRITE,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemReg,
    output logic [2:0] ALUOp,
    output logic       ALUScr,
    output logic       RegWrite,
    output logic [1:0] AuipcLui,
    output logic       ILLEGAL,
    output logic       BUS_ERR,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    // Class encoding doubles as the ALUOp value driven to the ALU control.
    typedef enum logic [2:0] {
        C_R     = 3'b000,
        C_IMM   = 3'b001,
        C_LOAD  = 3'b010,
        C_STORE = 3'b011,
        C_BR    = 3'b100,
        C_LUI   = 3'b101,
        C_AUIPC = 3'b110,
        C_JAL   = 3'b111
    } cls_t;

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX - 1);

    state_t     state_q, state_d;
    logic [6:0] opc_q;
    logic [7:0] wait_cnt;
    logic       ill_q, berr_q;
    cls_t       cls;
    logic       mem_act, timeout, ill_det;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111: is_legal = 1'b1;
            default:                                        is_legal = 1'b0;
        endcase
    endfunction

    function automatic cls_t classify(input logic [6:0] op);
        case (op)
            7'b0010011: classify = C_IMM;
            7'b0000011: classify = C_LOAD;
            7'b0100011: classify = C_STORE;
            7'b1100011: classify = C_BR;
            7'b0110111: classify = C_LUI;
            7'b0010111: classify = C_AUIPC;
            7'b1101111: classify = C_JAL;
            default:    classify = C_R;
        endcase
    endfunction

    assign cls     = classify(opc_q);
    assign mem_act = (state_q == S_FETCH) || (state_q == S_MEM);
    // A ready in the limit cycle still completes the access normally.
    assign timeout = mem_act && !MEM_READY && (wait_cnt == WAIT_LIM);
    assign ill_det = (state_q == S_DECODE) && !is_legal(OPCODE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            opc_q    <= '0;
            wait_cnt <= '0;
            ill_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) opc_q <= OPCODE;
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (mem_act && !MEM_READY)
                wait_cnt <= wait_cnt + 8'd1;
            if (ill_det) ill_q  <= 1'b1;
            if (timeout) berr_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        PC_WRITE = 1'b0;
        PC_SRC   = 2'b00;
        IR_WRITE = 1'b0;
        MemRead  = 1'b1;
        MemWrite = 1'b1;
        MemReg   = 1'b0;
        ALUOp    = 3'b000;
        ALUScr   = 1'b0;
        RegWrite = 1'b0;
        AuipcLui = 2'b10;

        case (state_q)
            S_IDLE: begin
                if (RUN) state_d = S_FETCH;
            end
            S_FETCH: begin
                MemRead  = 1'b0;
                IR_WRITE = MEM_READY;
                if (MEM_READY)    state_d = S_DECODE;
                else if (timeout) state_d = S_TRAP;
            end
            S_DECODE: begin
                state_d = ill_det ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                ALUOp    = cls;
                ALUScr   = (cls == C_IMM) || (cls == C_LOAD) || (cls == C_STORE);
                AuipcLui = (cls == C_LUI) ? 2'b01 : (cls == C_AUIPC) ? 2'b00 : 2'b10;
                case (cls)
                    C_BR: begin
                        PC_WRITE = 1'b1;
                        PC_SRC   = BR_TAKEN ? 2'b01 : 2'b00;
                        state_d  = RUN ? S_FETCH : S_IDLE;
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM: begin
                ALUOp  = cls;
                ALUScr = 1'b1;
                if (cls == C_LOAD) begin
                    MemRead = 1'b0;
                    if (MEM_READY) state_d = S_WB;
                end else begin
                    // Store retires here; the PC update waits for the write to land.
                    MemWrite = 1'b0;
                    PC_WRITE = MEM_READY;
                    if (MEM_READY) state_d = RUN ? S_FETCH : S_IDLE;
                end
                if (!MEM_READY && timeout) state_d = S_TRAP;
            end
            S_WB: begin
                ALUOp    = cls;
                ALUScr   = (cls == C_IMM) || (cls == C_LOAD) || (cls == C_STORE);
                AuipcLui = (cls == C_LUI) ? 2'b01 : (cls == C_AUIPC) ? 2'b00 : 2'b10;
                RegWrite = 1'b1;
                MemReg   = (cls == C_LOAD);
                PC_WRITE = 1'b1;
                PC_SRC   = (cls == C_JAL) ? 2'b10 : 2'b00;
                state_d  = RUN ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ILLEGAL = ill_q;
    assign BUS_ERR = berr_q;
    assign STATE   = state_q;

endmodule
